imem_program_controller: RTL and testbench

// Sequences and shares the instruction memory between the debug loader and the CPU fetch path.

---
 rtl/imem_ctrl_pkg.sv | 35 +++
 rtl/imem_program_controller_if.sv | 37 +++
 rtl/imem_word_assembler.sv | 53 +++++
 rtl/imem_program_controller.sv | 149 ++++++++++++++
 tb/tb_imem_program_controller.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction-memory program controller:
// FSM state and command encodings, end-of-program marker and the address-width helper.
package imem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } ctrl_state_e;

  typedef enum logic [1:0] {
    CMD_STOP = 2'd0,
    CMD_LOAD = 2'd1,
    CMD_RUN  = 2'd2,
    CMD_STEP = 2'd3
  } ctrl_cmd_e;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  // Same sizing rule as the instruction memory: counts significant bits of depth,
  // so a 2048-word memory yields 12.
  function automatic int clogb2(input int depth);
    int result;
    int remaining;
    result    = 0;
    remaining = depth;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/imem_program_controller_if.sv
// Debug byte stream and instruction-memory bus seen by the program controller.
// The master modport is the controller side; slave is the debug unit / memory side.
interface imem_program_controller_if #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8,
  parameter int ADDR_W  = 12
);

  logic [NB_BYTE-1:0] rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic [ADDR_W-1:0]  mem_addr;
  logic [NB_DATA-1:0] mem_wdata;
  logic               mem_we;
  logic               mem_enable;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_enable
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_enable
  );

endinterface

// File: rtl/imem_word_assembler.sv
// Packs an MSB-first byte stream into NB_DATA words; o_word_valid pulses for one cycle
// after the last byte of a word is taken. i_flush drops any partially assembled word.
module imem_word_assembler #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_flush,
  input  logic [NB_BYTE-1:0] i_byte,
  input  logic               i_byte_valid,
  output logic [NB_DATA-1:0] o_word,
  output logic               o_word_valid
);

  localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
  localparam int CNT_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [NB_DATA-1:0] shift_reg;
  logic [NB_DATA-1:0] shift_next;
  logic [CNT_W-1:0]   byte_cnt;

  // Earlier bytes move toward the MSB as each new byte enters at the bottom.
  assign shift_next = (shift_reg << NB_BYTE) | NB_DATA'(i_byte);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shift_reg    <= '0;
      byte_cnt     <= '0;
      o_word       <= '0;
      o_word_valid <= 1'b0;
    end else begin
      o_word_valid <= 1'b0;
      if (i_flush) begin
        shift_reg <= '0;
        byte_cnt  <= '0;
      end else if (i_byte_valid) begin
        if (byte_cnt == LAST_BYTE) begin
          shift_reg    <= '0;
          byte_cnt     <= '0;
          o_word       <= shift_next;
          o_word_valid <= 1'b1;
        end else begin
          shift_reg <= shift_next;
          byte_cnt  <= byte_cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/imem_program_controller.sv
// Arbitrates the instruction memory between the debug loader (LOAD) and the CPU fetch
// path (RUN / STEP), and drives the pipeline global enable.
module imem_program_controller
  import imem_ctrl_pkg::*;
#(
  parameter int                 NB_DATA            = 32,
  parameter int                 NB_BYTE            = 8,
  parameter int                 N_ADDR             = 2048,
  parameter int                 LOG2_N_INSMEM_ADDR = clogb2(N_ADDR),
  parameter logic [NB_DATA-1:0] HALT_WORD          = NB_DATA'(HALT_WORD_DEFAULT)
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [1:0]                    i_cmd,
  input  logic                          i_cmd_valid,
  input  logic [LOG2_N_INSMEM_ADDR-1:0] i_fetch_addr,
  input  logic                          i_cpu_halted,
  imem_program_controller_if.master     bus,
  output logic                          o_cpu_enable,
  output logic                          o_loaded,
  output logic                          o_load_done,
  output logic [LOG2_N_INSMEM_ADDR:0]   o_word_count,
  output logic [1:0]                    o_state
);

  localparam int AW = LOG2_N_INSMEM_ADDR;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N_ADDR - 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   COUNT_MAX = (AW + 1)'(N_ADDR);
  localparam logic [AW:0]   COUNT_ONE = (AW + 1)'(1);

  ctrl_state_e        state;
  ctrl_state_e        state_d;
  ctrl_cmd_e          cmd;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      wr_ptr_d;
  logic [AW:0]        word_count;
  logic [AW:0]        word_count_d;
  logic               loaded;
  logic               loaded_d;
  logic               load_done;
  logic               load_done_d;
  logic               enable_q;
  logic               stop_req;
  logic               load_ending;
  logic               rx_fire;
  logic               asm_flush;
  logic [NB_DATA-1:0] asm_word;
  logic               asm_valid;

  assign cmd      = ctrl_cmd_e'(i_cmd);
  assign stop_req = i_cmd_valid && (cmd == CMD_STOP);

  // The write cycle of the final word must not take another byte, so ready drops
  // as soon as the word being written is known to end the load.
  assign load_ending  = asm_valid && ((asm_word == HALT_WORD) || (wr_ptr == LAST_ADDR));
  assign bus.rx_ready = (state == ST_LOAD) && !load_ending && !i_reset;
  assign rx_fire      = bus.rx_valid && bus.rx_ready;
  assign asm_flush    = (state_d != ST_LOAD);

  imem_word_assembler #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_word_assembler (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_flush      (asm_flush),
    .i_byte       (bus.rx_data),
    .i_byte_valid (rx_fire),
    .o_word       (asm_word),
    .o_word_valid (asm_valid)
  );

  always_comb begin
    state_d      = state;
    wr_ptr_d     = wr_ptr;
    word_count_d = word_count;
    loaded_d     = loaded;
    load_done_d  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          unique case (cmd)
            CMD_LOAD: begin
              state_d      = ST_LOAD;
              wr_ptr_d     = '0;
              word_count_d = '0;
              loaded_d     = 1'b0;
            end
            CMD_RUN:  if (loaded) state_d = ST_RUN;
            CMD_STEP: if (loaded) state_d = ST_STEP;
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      ST_LOAD: begin
        // The pointer parks on the last address instead of wrapping.
        if (asm_valid) begin
          if (word_count != COUNT_MAX) word_count_d = word_count + COUNT_ONE;
          if (wr_ptr != LAST_ADDR)     wr_ptr_d     = wr_ptr + PTR_ONE;
        end
        if (stop_req) begin
          state_d  = ST_IDLE;
          loaded_d = 1'b0;
        end else if (load_ending) begin
          state_d     = ST_IDLE;
          loaded_d    = 1'b1;
          load_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop_req || i_cpu_halted) state_d = ST_IDLE;
      end
      ST_STEP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      word_count <= '0;
      loaded     <= 1'b0;
      load_done  <= 1'b0;
      enable_q   <= 1'b0;
    end else begin
      state      <= state_d;
      wr_ptr     <= wr_ptr_d;
      word_count <= word_count_d;
      loaded     <= loaded_d;
      load_done  <= load_done_d;
      enable_q   <= (state_d == ST_RUN) || (state_d == ST_STEP);
    end
  end

  assign bus.mem_addr   = (state == ST_LOAD) ? wr_ptr : i_fetch_addr;
  assign bus.mem_wdata  = asm_word;
  assign bus.mem_we     = asm_valid;
  assign bus.mem_enable = enable_q;
  assign o_cpu_enable   = enable_q;
  assign o_loaded       = loaded;
  assign o_load_done    = load_done;
  assign o_word_count   = word_count;
  assign o_state        = state;

endmodule

// File: tb/tb_imem_program_controller.sv
// Bench for imem_program_controller on an 8-word memory: expected memory writes are
// queued as bytes are streamed and matched by a write monitor; control behaviour is checked inline.
module tb_imem_program_controller;
  import imem_ctrl_pkg::*;

  localparam int NB_DATA = 32;
  localparam int NB_BYTE = 8;
  localparam int N_ADDR  = 8;
  localparam int ADDR_W  = 4;

  logic              i_clock      = 1'b0;
  logic              i_reset      = 1'b1;
  logic [1:0]        i_cmd        = 2'd0;
  logic              i_cmd_valid  = 1'b0;
  logic [ADDR_W-1:0] i_fetch_addr = '0;
  logic              i_cpu_halted = 1'b0;
  logic              o_cpu_enable;
  logic              o_loaded;
  logic              o_load_done;
  logic [ADDR_W:0]   o_word_count;
  logic [1:0]        o_state;

  imem_program_controller_if #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE),
    .ADDR_W  (ADDR_W)
  ) bus ();

  imem_program_controller #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE),
    .N_ADDR  (N_ADDR)
  ) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_cmd        (i_cmd),
    .i_cmd_valid  (i_cmd_valid),
    .i_fetch_addr (i_fetch_addr),
    .i_cpu_halted (i_cpu_halted),
    .bus          (bus),
    .o_cpu_enable (o_cpu_enable),
    .o_loaded     (o_loaded),
    .o_load_done  (o_load_done),
    .o_word_count (o_word_count),
    .o_state      (o_state)
  );

  always #5 i_clock = ~i_clock;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [NB_DATA-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] prog[$];
  wr_t         mon_e;
  int          vectors     = 0;
  int          miscompares = 0;

  task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors = vectors + 1;
    if (actual !== expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Every memory write must match the oldest outstanding expected write.
  always @(negedge i_clock) begin
    if (bus.mem_we === 1'b1) begin
      check_output("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_output("write_addr", 64'(bus.mem_addr), 64'(mon_e.addr));
        check_output("write_data", 64'(bus.mem_wdata), 64'(mon_e.data));
      end
    end
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic send_cmd(input ctrl_cmd_e c);
    i_cmd       = c;
    i_cmd_valid = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
    i_cmd       = CMD_STOP;
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    bit accepted;
    accepted     = 1'b0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int n = 0; n < 16 && !accepted; n++) begin
      if (bus.rx_ready === 1'b1) accepted = 1'b1;
      tick();
    end
    bus.rx_valid = 1'b0;
    check_output("rx_accept", 64'(accepted), 64'd1);
  endtask

  task automatic check_reset_state();
    @(negedge i_clock);
    check_output("rst_state",      64'(o_state),        64'd0);
    check_output("rst_rx_ready",   64'(bus.rx_ready),   64'd0);
    check_output("rst_mem_we",     64'(bus.mem_we),     64'd0);
    check_output("rst_mem_wdata",  64'(bus.mem_wdata),  64'd0);
    check_output("rst_mem_enable", 64'(bus.mem_enable), 64'd0);
    check_output("rst_cpu_enable", 64'(o_cpu_enable),   64'd0);
    check_output("rst_loaded",     64'(o_loaded),       64'd0);
    check_output("rst_load_done",  64'(o_load_done),    64'd0);
    check_output("rst_word_count", 64'(o_word_count),   64'd0);
    check_output("rst_mem_addr",   64'(bus.mem_addr),   64'd0);
  endtask

  // Streams prog[] whose last word is expected to end the load (halt word or last address).
  task automatic load_program();
    logic [31:0] w;
    wr_t         e;
    send_cmd(CMD_LOAD);
    @(negedge i_clock);
    check_output("load_state",      64'(o_state),      64'(ST_LOAD));
    check_output("load_ready",      64'(bus.rx_ready), 64'd1);
    check_output("load_loaded_clr", 64'(o_loaded),     64'd0);
    check_output("load_count_clr",  64'(o_word_count), 64'd0);
    for (int wi = 0; wi < prog.size(); wi++) begin
      w      = prog[wi];
      e.addr = ADDR_W'(wi);
      e.data = w;
      exp_q.push_back(e);
      for (int k = 3; k >= 0; k--) apply_stimulus(w[8*k +: 8]);
    end
    bus.rx_data  = 8'h5A;
    bus.rx_valid = 1'b1;
    @(negedge i_clock);
    check_output("final_write_we",    64'(bus.mem_we),   64'd1);
    check_output("final_write_ready", 64'(bus.rx_ready), 64'd0);
    tick();
    @(negedge i_clock);
    check_output("load_done_pulse", 64'(o_load_done),  64'd1);
    check_output("load_end_state",  64'(o_state),      64'(ST_IDLE));
    check_output("load_end_loaded", 64'(o_loaded),     64'd1);
    check_output("load_end_count",  64'(o_word_count), 64'(prog.size()));
    check_output("load_end_ready",  64'(bus.rx_ready), 64'd0);
    tick();
    @(negedge i_clock);
    check_output("load_done_width", 64'(o_load_done), 64'd0);
    check_output("load_no_extra_we", 64'(bus.mem_we), 64'd0);
    bus.rx_valid = 1'b0;
    check_output("load_queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;
    check_reset_state();

    // RUN and STEP with nothing loaded stay in IDLE.
    send_cmd(CMD_RUN);
    @(negedge i_clock);
    check_output("run_unloaded_state", 64'(o_state),      64'(ST_IDLE));
    check_output("run_unloaded_en",    64'(o_cpu_enable), 64'd0);
    send_cmd(CMD_STEP);
    @(negedge i_clock);
    check_output("step_unloaded_state", 64'(o_state),      64'(ST_IDLE));
    check_output("step_unloaded_en",    64'(o_cpu_enable), 64'd0);

    prog = '{32'h1234_5678, 32'hABCD_EF01, 32'hFFFF_FFFF};
    load_program();

    // Free run: six enabled cycles, address follows the PC, LOAD mid-run ignored.
    send_cmd(CMD_RUN);
    for (int i = 0; i < 6; i++) begin
      i_fetch_addr = ADDR_W'(i);
      i_cpu_halted = (i == 5);
      i_cmd        = CMD_LOAD;
      i_cmd_valid  = (i == 2);
      @(negedge i_clock);
      check_output("run_state",      64'(o_state),        64'(ST_RUN));
      check_output("run_cpu_en",     64'(o_cpu_enable),   64'd1);
      check_output("run_mem_en",     64'(bus.mem_enable), 64'd1);
      check_output("run_mem_addr",   64'(bus.mem_addr),   64'(i));
      tick();
    end
    i_cpu_halted = 1'b0;
    i_cmd_valid  = 1'b0;
    i_cmd        = CMD_STOP;
    @(negedge i_clock);
    check_output("halt_state",  64'(o_state),        64'(ST_IDLE));
    check_output("halt_cpu_en", 64'(o_cpu_enable),   64'd0);
    check_output("halt_mem_en", 64'(bus.mem_enable), 64'd0);
    check_output("halt_loaded", 64'(o_loaded),       64'd1);

    for (int s = 0; s < 2; s++) begin
      send_cmd(CMD_STEP);
      @(negedge i_clock);
      check_output("step_state",  64'(o_state),      64'(ST_STEP));
      check_output("step_cpu_en", 64'(o_cpu_enable), 64'd1);
      tick();
      @(negedge i_clock);
      check_output("step_after_state",  64'(o_state),      64'(ST_IDLE));
      check_output("step_after_cpu_en", 64'(o_cpu_enable), 64'd0);
    end

    // Aborted load: partial word must not be written nor leak into the next load.
    i_fetch_addr = '0;
    send_cmd(CMD_LOAD);
    apply_stimulus(8'hAA);
    apply_stimulus(8'hBB);
    send_cmd(CMD_STOP);
    @(negedge i_clock);
    check_output("stop_state",  64'(o_state),    64'(ST_IDLE));
    check_output("stop_loaded", 64'(o_loaded),   64'd0);
    check_output("stop_we",     64'(bus.mem_we), 64'd0);
    prog = '{32'h1122_3344, 32'hFFFF_FFFF};
    load_program();

    // Fill the whole memory without a halt word.
    prog.delete();
    for (int i = 0; i < N_ADDR; i++) prog.push_back(32'h0102_0304 + 32'h1111_1111 * 32'(i));
    load_program();

    // Reset while running.
    send_cmd(CMD_RUN);
    i_fetch_addr = 4'd3;
    @(negedge i_clock);
    check_output("pre_reset_run", 64'(o_state), 64'(ST_RUN));
    tick();
    i_reset      = 1'b1;
    i_fetch_addr = '0;
    tick();
    i_reset = 1'b0;
    check_reset_state();

    // Reset in the middle of a word with a byte offered in the reset cycle.
    send_cmd(CMD_LOAD);
    apply_stimulus(8'hAA);
    apply_stimulus(8'hBB);
    i_reset      = 1'b1;
    bus.rx_data  = 8'h99;
    bus.rx_valid = 1'b1;
    #1;
    check_output("ready_during_reset", 64'(bus.rx_ready), 64'd0);
    tick();
    i_reset      = 1'b0;
    bus.rx_valid = 1'b0;
    check_reset_state();
    prog = '{32'h5566_7788, 32'hFFFF_FFFF};
    load_program();

    check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
